mux_scan: RTL and testbench



---
 rtl/mux_scan.sv | 192 +++++++++++++++++++
 tb/tb_mux_scan.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan.sv
// Registered N-channel, W-bit multiplexer with manual capture and masked scan modes,
// valid/ready output. Define MUX_SCAN_PARITY_EN to add the even-parity output out_par.
module mux_scan #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic                     start,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     scan_done,
  output logic                     sel_err
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic                     out_par
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } hit_t;

  // Lowest set bit of m at or above position from.
  function automatic hit_t find_from(input logic [NUM_CH-1:0] m, input int unsigned from);
    hit_t h;
    h = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!h.found && i >= from && m[i]) begin
        h.found = 1'b1;
        h.idx   = SEL_W'(i);
      end
    end
    return h;
  endfunction

  function automatic logic [DATA_W-1:0] ch_word(input logic [NUM_CH*DATA_W-1:0] d,
                                                input logic [SEL_W-1:0] idx);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (SEL_W'(i) == idx) w = d[i*DATA_W +: DATA_W];
    end
    return w;
  endfunction

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_ch_q, out_ch_d;
  logic                out_valid_q, out_valid_d;
  logic                scan_done_q, scan_done_d;
  logic                sel_err_q, sel_err_d;
  logic                par_q, par_d;

  logic                slot_free;
  logic                sel_ok;
  logic                load;
  logic [SEL_W-1:0]    load_idx;
  logic [DATA_W-1:0]   load_word;
  hit_t                first_hit, start_next, scan_next;

  assign busy      = (state_q != IDLE) || out_valid_q;
  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    mask_d      = mask_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q && !out_ready;
    par_d       = par_q;
    scan_done_d = 1'b0;
    sel_err_d   = 1'b0;
    load        = 1'b0;
    load_idx    = '0;
    load_word   = '0;
    sel_ok      = 1'b0;

    // Range check folded into the loop so out-of-range sel_in never indexes ch_en.
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (SEL_W'(i) == sel_in && ch_en[i]) sel_ok = 1'b1;
    end

    first_hit  = find_from(ch_en, 0);
    start_next = find_from(ch_en, int'(first_hit.idx) + 1);
    scan_next  = find_from(mask_q, int'(ptr_q) + 1);

    case (state_q)
      IDLE: begin
        if (start && !busy) begin
          if (!mode) begin
            if (sel_ok) begin
              load     = 1'b1;
              load_idx = sel_in;
            end else begin
              sel_err_d = 1'b1;
            end
          end else begin
            mask_d = ch_en;
            if (!first_hit.found) begin
              scan_done_d = 1'b1;
            end else begin
              load     = 1'b1;
              load_idx = first_hit.idx;
              if (start_next.found) begin
                ptr_d   = start_next.idx;
                state_d = SCAN;
              end else begin
                state_d = DONE;
              end
            end
          end
        end
      end
      SCAN: begin
        if (slot_free) begin
          load     = 1'b1;
          load_idx = ptr_q;
          if (scan_next.found) ptr_d = scan_next.idx;
          else                 state_d = DONE;
        end
      end
      DONE: begin
        if (slot_free) begin
          scan_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      load_word   = ch_word(data_in, load_idx);
      out_data_d  = load_word;
      out_ch_d    = load_idx;
      out_valid_d = 1'b1;
      par_d       = ^load_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      mask_q      <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      scan_done_q <= 1'b0;
      sel_err_q   <= 1'b0;
      par_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mask_q      <= mask_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      scan_done_q <= scan_done_d;
      sel_err_q   <= sel_err_d;
      par_q       <= par_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign scan_done = scan_done_q;
  assign sel_err   = sel_err_q;

`ifdef MUX_SCAN_PARITY_EN
  assign out_par = par_q;
`else
  logic par_unused;
  assign par_unused = par_q;
`endif

endmodule

// File: tb/tb_mux_scan.sv
// Directed self-checking bench for mux_scan: an 8-channel instance for the main
// scenarios plus a 6-channel instance for out-of-range manual selection.
module tb_mux_scan;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [63:0] data_in;
  logic [7:0]  ch_en;
  logic        mode;
  logic [2:0]  sel_in;
  logic        start;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_ch;
  logic        out_valid, busy, scan_done, sel_err;

  logic [47:0] data6;
  logic [5:0]  ch_en6;
  logic        mode6;
  logic [2:0]  sel6;
  logic        start6, ready6;
  logic [7:0]  out_data6;
  logic [2:0]  out_ch6;
  logic        out_valid6, busy6, scan_done6, sel_err6;

  int tests = 0;
  int fails = 0;

  mux_scan #(.NUM_CH(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .ch_en(ch_en), .mode(mode),
    .sel_in(sel_in), .start(start), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .scan_done(scan_done), .sel_err(sel_err)
  );

  mux_scan #(.NUM_CH(6), .DATA_W(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .data_in(data6), .ch_en(ch_en6), .mode(mode6),
    .sel_in(sel6), .start(start6), .out_data(out_data6), .out_ch(out_ch6),
    .out_valid(out_valid6), .out_ready(ready6), .busy(busy6),
    .scan_done(scan_done6), .sel_err(sel_err6)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_scan_data;
    for (int i = 0; i < 8; i++) data_in[i*8 +: 8] = 8'h10 + 8'(i);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; sel_in = '0; ch_en = '0; out_ready = 1'b1;
    start6 = 1'b0; mode6 = 1'b0; sel6 = '0; ch_en6 = '1; ready6 = 1'b1;
    load_scan_data();
    for (int i = 0; i < 6; i++) data6[i*8 +: 8] = 8'h30 + 8'(i);
    #12;
    tests++;
    if ({out_data, out_ch, out_valid, busy, scan_done, sel_err} !== 15'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0", {out_data, out_ch, out_valid, busy, scan_done, sel_err});
    end
    tests++;
    if ({out_valid6, busy6, sel_err6} !== 3'b000) begin
      fails++;
      $display("FAIL reset_outputs6: got %b expected 000", {out_valid6, busy6, sel_err6});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_manual;
    data_in[5*8 +: 8] = 8'hA5;
    ch_en = 8'hFF; mode = 1'b0; sel_in = 3'd5; start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    tests++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 3'd5, 8'hA5}) begin
      fails++;
      $display("FAIL manual_load: got v=%b ch=%0d d=%h expected v=1 ch=5 d=a5", out_valid, out_ch, out_data);
    end
    for (int k = 0; k < 4; k++) begin
      // First held cycle also requests a different channel while busy; it must be ignored.
      start = (k == 0); sel_in = 3'd2;
      tick();
      start = 1'b0;
      tests++;
      if ({out_valid, busy, sel_err, out_ch, out_data} !== {1'b1, 1'b1, 1'b0, 3'd5, 8'hA5}) begin
        fails++;
        $display("FAIL manual_hold%0d: got v=%b busy=%b err=%b ch=%0d d=%h expected v=1 busy=1 err=0 ch=5 d=a5",
                 k, out_valid, busy, sel_err, out_ch, out_data);
      end
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if ({out_valid, busy} !== 2'b00) begin
      fails++;
      $display("FAIL manual_accept: got v=%b busy=%b expected v=0 busy=0", out_valid, busy);
    end
    load_scan_data();
  endtask

  task automatic test_scan;
    logic [2:0] exp_ch [4];
    exp_ch = '{3'd0, 3'd2, 3'd5, 3'd7};
    ch_en = 8'b1010_0101; mode = 1'b1; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if ({out_valid, scan_done, out_ch, out_data} !== {1'b1, 1'b0, exp_ch[k], 8'h10 + 8'(exp_ch[k])}) begin
        fails++;
        $display("FAIL scan_xfer%0d: got v=%b done=%b ch=%0d d=%h expected v=1 done=0 ch=%0d d=%h",
                 k, out_valid, scan_done, out_ch, out_data, exp_ch[k], 8'h10 + 8'(exp_ch[k]));
      end
      tick();
    end
    tests++;
    if ({scan_done, out_valid} !== 2'b10) begin
      fails++;
      $display("FAIL scan_done_pulse: got done=%b v=%b expected done=1 v=0", scan_done, out_valid);
    end
    tick();
    tests++;
    if ({scan_done, busy} !== 2'b00) begin
      fails++;
      $display("FAIL scan_done_once: got done=%b busy=%b expected 0 0", scan_done, busy);
    end
  endtask

  task automatic test_backpressure;
    ch_en = 8'b1010_0101; mode = 1'b1; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; ch_en = 8'h00; mode = 1'b0;
    tests++;
    if ({out_valid, out_ch} !== {1'b1, 3'd0}) begin
      fails++;
      $display("FAIL bp_first: got v=%b ch=%0d expected v=1 ch=0", out_valid, out_ch);
    end
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 3'd2, 8'h12}) begin
        fails++;
        $display("FAIL bp_hold%0d: got v=%b ch=%0d d=%h expected v=1 ch=2 d=12", k, out_valid, out_ch, out_data);
      end
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 3'd5, 8'h15}) begin
      fails++;
      $display("FAIL bp_after5: got v=%b ch=%0d d=%h expected v=1 ch=5 d=15", out_valid, out_ch, out_data);
    end
    tick();
    tests++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 3'd7, 8'h17}) begin
      fails++;
      $display("FAIL bp_after7: got v=%b ch=%0d d=%h expected v=1 ch=7 d=17", out_valid, out_ch, out_data);
    end
    tick();
    tests++;
    if ({scan_done, out_valid} !== 2'b10) begin
      fails++;
      $display("FAIL bp_done: got done=%b v=%b expected done=1 v=0", scan_done, out_valid);
    end
    tick();
  endtask

  task automatic test_empty_mask;
    ch_en = 8'h00; mode = 1'b1; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if ({scan_done, out_valid, busy} !== 3'b100) begin
      fails++;
      $display("FAIL empty_done: got done=%b v=%b busy=%b expected 1 0 0", scan_done, out_valid, busy);
    end
    tick();
    tests++;
    if ({scan_done, out_valid, busy} !== 3'b000) begin
      fails++;
      $display("FAIL empty_after: got done=%b v=%b busy=%b expected 0 0 0", scan_done, out_valid, busy);
    end
  endtask

  task automatic test_manual_errors;
    ch_en = 8'hF7; mode = 1'b0; sel_in = 3'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if ({sel_err, out_valid} !== 2'b10) begin
      fails++;
      $display("FAIL err_disabled: got err=%b v=%b expected err=1 v=0", sel_err, out_valid);
    end
    tick();
    tests++;
    if (sel_err !== 1'b0) begin
      fails++;
      $display("FAIL err_pulse_width: got err=%b expected 0", sel_err);
    end
    sel6 = 3'd7; start6 = 1'b1;
    tick();
    start6 = 1'b0;
    tests++;
    if ({sel_err6, out_valid6} !== 2'b10) begin
      fails++;
      $display("FAIL err_range7: got err=%b v=%b expected err=1 v=0", sel_err6, out_valid6);
    end
    sel6 = 3'd6; start6 = 1'b1;
    tick();
    start6 = 1'b0;
    tests++;
    if ({sel_err6, out_valid6} !== 2'b10) begin
      fails++;
      $display("FAIL err_range6: got err=%b v=%b expected err=1 v=0", sel_err6, out_valid6);
    end
    sel6 = 3'd4; start6 = 1'b1;
    tick();
    start6 = 1'b0;
    tests++;
    if ({sel_err6, out_valid6, out_ch6, out_data6} !== {1'b0, 1'b1, 3'd4, 8'h34}) begin
      fails++;
      $display("FAIL ch6_manual4: got err=%b v=%b ch=%0d d=%h expected err=0 v=1 ch=4 d=34",
               sel_err6, out_valid6, out_ch6, out_data6);
    end
    tick();
  endtask

  task automatic test_async_reset;
    ch_en = 8'b1010_0101; mode = 1'b1; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, busy, out_ch, out_data, scan_done} !== 14'h0) begin
      fails++;
      $display("FAIL areset_immediate: got v=%b busy=%b ch=%0d d=%h done=%b expected all 0",
               out_valid, busy, out_ch, out_data, scan_done);
    end
    #2 rst_n = 1'b1;
    tick();
    tests++;
    if ({scan_done, out_valid, busy} !== 3'b000) begin
      fails++;
      $display("FAIL areset_no_pulse: got done=%b v=%b busy=%b expected 0 0 0", scan_done, out_valid, busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 3'd0, 8'h10}) begin
      fails++;
      $display("FAIL areset_restart0: got v=%b ch=%0d d=%h expected v=1 ch=0 d=10", out_valid, out_ch, out_data);
    end
    tick();
    tests++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 3'd2, 8'h12}) begin
      fails++;
      $display("FAIL areset_restart2: got v=%b ch=%0d d=%h expected v=1 ch=2 d=12", out_valid, out_ch, out_data);
    end
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_backpressure();
    test_empty_mask();
    test_manual_errors();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
